// File: rtl/mem_arb_pkg.sv
// Shared state encoding and requester constants for the memory port arbiter.
package mem_arb_pkg;

    localparam int NREQ      = 4;
    localparam int REQ_LDA   = 0;
    localparam int REQ_LDB   = 1;
    localparam int REQ_ST    = 2;
    localparam int REQ_FETCH = 3;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_BURST = 2'd1,
        S_TURN  = 2'd2
    } arb_state_e;

endpackage

// File: rtl/mem_port_arbiter_rr_pick4.sv
// Combinational round-robin picker: first requester with req high, scanning
// last+1, last+2, ... modulo 4.
module rr_pick4 (
    input  logic [3:0] req,
    input  logic [1:0] last,
    output logic       valid,
    output logic [1:0] winner
);

    logic [1:0] idx;

    // Walk from the farthest offset down so the nearest candidate is assigned last.
    always_comb begin
        valid  = 1'b0;
        winner = last;
        idx    = last;
        for (int k = 4; k >= 1; k--) begin
            idx = last + 2'(k);
            if (req[idx]) begin
                valid  = 1'b1;
                winner = idx;
            end
        end
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// Round-robin arbiter and burst sequencer for the shared 16-bit memory port.
// Optional macro FETCH_PRIO_EN: requester 3 wins any arbitration it requests.
//
// state   | meaning
// S_IDLE  | no owner; requests sampled every edge
// S_BURST | grant held until the final acknowledged beat
// S_TURN  | one dead cycle between bursts (TURN=1 only)
module mem_port_arbiter
    import mem_arb_pkg::*;
#(
    parameter int LENW = 4,
    parameter int TURN = 1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [NREQ-1:0]      req,
    input  logic [NREQ*LENW-1:0] len,
    input  logic                 beat_ack,
    output logic [NREQ-1:0]      gnt,
    output logic [1:0]           sel,
    output logic                 busy,
    output logic [LENW-1:0]      remain,
    output logic [NREQ-1:0]      done
);

    localparam bit TURN_EN = (TURN != 0);

    arb_state_e      state_q, state_d;
    logic [NREQ-1:0] gnt_q, gnt_d;
    logic [1:0]      sel_q, sel_d;
    logic            busy_q, busy_d;
    logic [LENW-1:0] remain_q, remain_d;
    logic [NREQ-1:0] done_q, done_d;
    logic [1:0]      last_q, last_d;
    logic            prio_q, prio_d;

    logic [1:0]      arb_last;
    logic            rr_valid;
    logic [1:0]      rr_winner;
    logic [1:0]      win;
    logic            win_prio;
    logic [LENW-1:0] len_win;
    logic            final_beat;
    logic            grant_now;

    // A burst that finishes re-arbitrates against its own index, unless it was a priority win.
    assign arb_last = (state_q == S_BURST && !prio_q) ? sel_q : last_q;

    rr_pick4 u_pick (
        .req    (req),
        .last   (arb_last),
        .valid  (rr_valid),
        .winner (rr_winner)
    );

`ifdef FETCH_PRIO_EN
    assign win      = req[REQ_FETCH] ? 2'(REQ_FETCH) : rr_winner;
    assign win_prio = req[REQ_FETCH];
`else
    assign win      = rr_winner;
    assign win_prio = 1'b0;
`endif

    assign len_win    = len[win*LENW +: LENW];
    assign final_beat = (state_q == S_BURST) && beat_ack && (remain_q == LENW'(1));
    assign grant_now  = rr_valid && ((state_q == S_IDLE) || (final_beat && !TURN_EN));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= S_IDLE;
            gnt_q    <= '0;
            sel_q    <= '0;
            busy_q   <= 1'b0;
            remain_q <= '0;
            done_q   <= '0;
            last_q   <= 2'd3;
            prio_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            gnt_q    <= gnt_d;
            sel_q    <= sel_d;
            busy_q   <= busy_d;
            remain_q <= remain_d;
            done_q   <= done_d;
            last_q   <= last_d;
            prio_q   <= prio_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (rr_valid) state_d = S_BURST;
            S_BURST: begin
                if (final_beat) begin
                    if (TURN_EN)       state_d = S_TURN;
                    else if (rr_valid) state_d = S_BURST;
                    else               state_d = S_IDLE;
                end
            end
            S_TURN:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        gnt_d    = gnt_q;
        sel_d    = sel_q;
        busy_d   = busy_q;
        remain_d = remain_q;
        done_d   = '0;
        last_d   = last_q;
        prio_d   = prio_q;

        if (final_beat) begin
            done_d[sel_q] = 1'b1;
            if (!prio_q) last_d = sel_q;
        end

        if (grant_now) begin
            gnt_d    = NREQ'(1) << win;
            sel_d    = win;
            busy_d   = 1'b1;
            remain_d = (len_win == '0) ? LENW'(1) : len_win;
            prio_d   = win_prio;
        end else if (final_beat) begin
            gnt_d    = '0;
            busy_d   = 1'b0;
            remain_d = '0;
            prio_d   = 1'b0;
        end else if (state_q == S_BURST && beat_ack) begin
            remain_d = remain_q - LENW'(1);
        end
    end

    assign gnt    = gnt_q;
    assign sel    = sel_q;
    assign busy   = busy_q;
    assign remain = remain_q;
    assign done   = done_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench: a TURN=1 and a TURN=0 arbiter share stimulus and are each
// compared every cycle against a transaction-level reference model.
module tb_mem_port_arbiter;

    typedef struct packed {
        int owner;     // -1 when nobody holds the port
        int rem;
        bit in_turn;
        int last;
        bit prio;
        int sel;
        int done_idx;  // -1 when no burst finished on the last edge
    } model_t;

    logic        clk   = 1'b0;
    logic        rst_n = 1'b0;
    logic [3:0]  req   = '0;
    logic [15:0] len   = '0;
    logic        ack   = 1'b0;

    logic [3:0]  gnt1, done1, rem1, gnt0, done0, rem0;
    logic [1:0]  sel1, sel0;
    logic        busy1, busy0;
    logic [14:0] obs1, obs0;

    int     n_checks = 0;
    int     n_fail   = 0;
    model_t mt1, mt0;

    assign obs1 = {gnt1, sel1, busy1, rem1, done1};
    assign obs0 = {gnt0, sel0, busy0, rem0, done0};

    always #5 clk = ~clk;

    mem_port_arbiter #(.LENW(4), .TURN(1)) u_turn1 (
        .clk(clk), .rst_n(rst_n), .req(req), .len(len), .beat_ack(ack),
        .gnt(gnt1), .sel(sel1), .busy(busy1), .remain(rem1), .done(done1)
    );

    mem_port_arbiter #(.LENW(4), .TURN(0)) u_turn0 (
        .clk(clk), .rst_n(rst_n), .req(req), .len(len), .beat_ack(ack),
        .gnt(gnt0), .sel(sel0), .busy(busy0), .remain(rem0), .done(done0)
    );

    function automatic model_t model_reset();
        model_t m;
        m.owner = -1; m.rem = 0; m.in_turn = 1'b0; m.last = 3;
        m.prio = 1'b0; m.sel = 0; m.done_idx = -1;
        return m;
    endfunction

    function automatic model_t model_grant(model_t m, logic [3:0] r, logic [15:0] l);
        int w;
        w = -1;
        m.prio = 1'b0;
`ifdef FETCH_PRIO_EN
        if (r[3]) begin w = 3; m.prio = 1'b1; end
`endif
        for (int k = 1; k <= 4; k++)
            if (w < 0 && r[(m.last + k) % 4]) w = (m.last + k) % 4;
        m.owner = w;
        m.sel   = w;
        m.rem   = (l[w*4 +: 4] == 4'd0) ? 1 : int'(l[w*4 +: 4]);
        return m;
    endfunction

    function automatic model_t model_step(model_t m, logic [3:0] r, logic [15:0] l,
                                          logic a, bit turn);
        model_t n;
        n = m;
        n.done_idx = -1;
        if (m.in_turn) begin
            n.in_turn = 1'b0;
            return n;
        end
        if (m.owner < 0) begin
            if (r != 4'd0) n = model_grant(n, r, l);
            return n;
        end
        if (a) begin
            if (m.rem == 1) begin
                n.done_idx = m.owner;
                if (!m.prio) n.last = m.owner;
                n.owner = -1;
                n.rem   = 0;
                n.prio  = 1'b0;
                if (turn)            n.in_turn = 1'b1;
                else if (r != 4'd0)  n = model_grant(n, r, l);
            end else begin
                n.rem = m.rem - 1;
            end
        end
        return n;
    endfunction

    function automatic logic [14:0] exp_obs(model_t m);
        logic [3:0] g, d;
        g = (m.owner >= 0)    ? 4'(1 << m.owner)    : 4'd0;
        d = (m.done_idx >= 0) ? 4'(1 << m.done_idx) : 4'd0;
        return {g, 2'(m.sel), (m.owner >= 0), 4'(m.rem), d};
    endfunction

    function automatic int ohx(logic [3:0] g);
        int r;
        r = -1;
        for (int i = 0; i < 4; i++) if (g[i]) r = i;
        return r;
    endfunction

    task automatic tick();
        @(posedge clk);
        if (rst_n) begin
            mt1 = model_step(mt1, req, len, ack, 1'b1);
            mt0 = model_step(mt0, req, len, ack, 1'b0);
        end
        @(negedge clk);
    endtask

    task automatic drain();
        req = '0;
        ack = 1'b1;
        for (int i = 0; i < 20; i++) tick();
    endtask

    task automatic test_reset();
        mt1 = model_reset();
        mt0 = model_reset();
        #12;
        n_checks += 2;
        if (obs1 !== 15'h0) begin n_fail++; $display("FAIL reset_t1: got %h expected %h", obs1, 15'h0); end
        if (obs0 !== 15'h0) begin n_fail++; $display("FAIL reset_t0: got %h expected %h", obs0, 15'h0); end
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        n_checks += 2;
        if (obs1 !== exp_obs(mt1)) begin n_fail++; $display("FAIL idle_t1: got %h expected %h", obs1, exp_obs(mt1)); end
        if (obs0 !== exp_obs(mt0)) begin n_fail++; $display("FAIL idle_t0: got %h expected %h", obs0, exp_obs(mt0)); end
    endtask

    task automatic test_round_robin();
        int         order[$];
        logic [3:0] prev;
        string      s;
        prev = gnt1;
        req = 4'hF; len = 16'h2222; ack = 1'b1;
        for (int c = 0; c < 22; c++) begin
            tick();
            n_checks += 2;
            if (obs1 !== exp_obs(mt1)) begin n_fail++; $display("FAIL rr_t1 c%0d: got %h expected %h", c, obs1, exp_obs(mt1)); end
            if (obs0 !== exp_obs(mt0)) begin n_fail++; $display("FAIL rr_t0 c%0d: got %h expected %h", c, obs0, exp_obs(mt0)); end
            if (gnt1 != 4'd0 && prev == 4'd0) order.push_back(ohx(gnt1));
            prev = gnt1;
        end
`ifndef FETCH_PRIO_EN
        s = "";
        for (int i = 0; i < 5 && i < order.size(); i++)
            s = (i == 0) ? $sformatf("%0d", order[i]) : $sformatf("%s %0d", s, order[i]);
        n_checks++;
        if (s != "0 1 2 3 0") begin n_fail++; $display("FAIL rr_order: got '%s' expected '0 1 2 3 0'", s); end
`endif
    endtask

    task automatic test_beat_pattern();
        logic pat[4]  = '{1'b1, 1'b0, 1'b1, 1'b1};
        int   erem[4] = '{2, 2, 1, 0};
        int   ndone;
        drain();
        req = 4'b0100; len = 16'h0300; ack = 1'b0;
        tick();
        n_checks += 2;
        if (obs1 !== exp_obs(mt1)) begin n_fail++; $display("FAIL bp_grant_t1: got %h expected %h", obs1, exp_obs(mt1)); end
        if ({gnt1, sel1, rem1} !== {4'b0100, 2'd2, 4'd3}) begin
            n_fail++; $display("FAIL bp_grant: got gnt=%b sel=%0d rem=%0d expected gnt=0100 sel=2 rem=3", gnt1, sel1, rem1);
        end
        req = 4'b0000; len = 16'hFFFF;
        ndone = 0;
        for (int i = 0; i < 4; i++) begin
            ack = pat[i];
            tick();
            n_checks += 3;
            if (obs1 !== exp_obs(mt1)) begin n_fail++; $display("FAIL bp_t1 b%0d: got %h expected %h", i, obs1, exp_obs(mt1)); end
            if (obs0 !== exp_obs(mt0)) begin n_fail++; $display("FAIL bp_t0 b%0d: got %h expected %h", i, obs0, exp_obs(mt0)); end
            if (rem1 !== 4'(erem[i])) begin n_fail++; $display("FAIL bp_remain b%0d: got %0d expected %0d", i, rem1, erem[i]); end
            if (done1[2]) ndone++;
        end
        ack = 1'b0;
        for (int i = 0; i < 2; i++) begin
            tick();
            if (done1[2]) ndone++;
        end
        n_checks++;
        if (ndone != 1) begin n_fail++; $display("FAIL bp_done_count: got %0d expected 1", ndone); end
    endtask

    task automatic test_len_zero();
        drain();
        req = 4'b0010; len = 16'h0000; ack = 1'b1;
        tick();
        n_checks++;
        if (rem1 !== 4'd1) begin n_fail++; $display("FAIL lz_remain: got %0d expected 1", rem1); end
        req = 4'b0000;
        tick();
        n_checks += 3;
        if ({gnt1, done1} !== {4'b0000, 4'b0010}) begin
            n_fail++; $display("FAIL lz_done: got gnt=%b done=%b expected gnt=0000 done=0010", gnt1, done1);
        end
        if (obs1 !== exp_obs(mt1)) begin n_fail++; $display("FAIL lz_t1: got %h expected %h", obs1, exp_obs(mt1)); end
        if (obs0 !== exp_obs(mt0)) begin n_fail++; $display("FAIL lz_t0: got %h expected %h", obs0, exp_obs(mt0)); end
    endtask

    task automatic test_back_to_back();
        logic [3:0] prev;
        drain();
        req = 4'b0011; len = 16'h1111; ack = 1'b1;
        tick();
        prev = gnt0;
        for (int c = 0; c < 6; c++) begin
            tick();
            n_checks += 3;
            if (obs0 !== exp_obs(mt0)) begin n_fail++; $display("FAIL b2b_t0 c%0d: got %h expected %h", c, obs0, exp_obs(mt0)); end
            if (obs1 !== exp_obs(mt1)) begin n_fail++; $display("FAIL b2b_t1 c%0d: got %h expected %h", c, obs1, exp_obs(mt1)); end
            if (!busy0 || gnt0 == prev || !(gnt0 == 4'b0001 || gnt0 == 4'b0010)) begin
                n_fail++; $display("FAIL b2b_alt c%0d: got busy=%b gnt=%b prev=%b expected busy=1 alternating 0001/0010", c, busy0, gnt0, prev);
            end
            prev = gnt0;
        end
    endtask

    task automatic test_reset_mid_burst();
        drain();
        req = 4'b0001; len = 16'h0003; ack = 1'b1;
        tick();
        tick();
        n_checks++;
        if (rem1 !== 4'd2) begin n_fail++; $display("FAIL rst_pre_remain: got %0d expected 2", rem1); end
        #2;
        rst_n = 1'b0;
        #1;
        n_checks += 2;
        if (obs1 !== 15'h0) begin n_fail++; $display("FAIL rst_async_t1: got %h expected %h", obs1, 15'h0); end
        if (obs0 !== 15'h0) begin n_fail++; $display("FAIL rst_async_t0: got %h expected %h", obs0, 15'h0); end
        mt1 = model_reset();
        mt0 = model_reset();
        @(negedge clk);
        n_checks++;
        if (done1 !== 4'd0 || done0 !== 4'd0) begin n_fail++; $display("FAIL rst_no_done: got %b/%b expected 0000", done1, done0); end
        rst_n = 1'b1;
        req = 4'hF; len = 16'h1111;
        tick();
        n_checks += 2;
        if (obs1 !== exp_obs(mt1)) begin n_fail++; $display("FAIL rst_after_t1: got %h expected %h", obs1, exp_obs(mt1)); end
        if (obs0 !== exp_obs(mt0)) begin n_fail++; $display("FAIL rst_after_t0: got %h expected %h", obs0, exp_obs(mt0)); end
`ifndef FETCH_PRIO_EN
        n_checks++;
        if (gnt1 !== 4'b0001) begin n_fail++; $display("FAIL rst_first_winner: got %b expected 0001", gnt1); end
`endif
        req = 4'b0000;
    endtask

`ifdef FETCH_PRIO_EN
    task automatic test_fetch_prio();
        int         order[$];
        logic [3:0] prev;
        string      s;
        drain();
        req = 4'b0001; len = 16'h2222; ack = 1'b1;
        tick();
        order.push_back(ohx(gnt1));
        prev = gnt1;
        req = 4'b1011;
        for (int c = 0; c < 12; c++) begin
            tick();
            n_checks += 2;
            if (obs1 !== exp_obs(mt1)) begin n_fail++; $display("FAIL prio_t1 c%0d: got %h expected %h", c, obs1, exp_obs(mt1)); end
            if (obs0 !== exp_obs(mt0)) begin n_fail++; $display("FAIL prio_t0 c%0d: got %h expected %h", c, obs0, exp_obs(mt0)); end
            if (gnt1 != 4'd0 && prev == 4'd0) order.push_back(ohx(gnt1));
            prev = gnt1;
        end
        s = "";
        for (int i = 0; i < 3 && i < order.size(); i++)
            s = (i == 0) ? $sformatf("%0d", order[i]) : $sformatf("%s %0d", s, order[i]);
        n_checks++;
        if (s != "0 3 1") begin n_fail++; $display("FAIL prio_order: got '%s' expected '0 3 1'", s); end
    endtask
`endif

    task automatic test_random();
        for (int c = 0; c < 400; c++) begin
            if ($urandom_range(0, 3) == 0) req = 4'($urandom_range(0, 15));
            if ($urandom_range(0, 4) == 0) len = 16'($urandom);
            ack = ($urandom_range(0, 3) != 0);
            tick();
            n_checks += 2;
            if (obs1 !== exp_obs(mt1)) begin n_fail++; $display("FAIL rand_t1 c%0d: got %h expected %h", c, obs1, exp_obs(mt1)); end
            if (obs0 !== exp_obs(mt0)) begin n_fail++; $display("FAIL rand_t0 c%0d: got %h expected %h", c, obs0, exp_obs(mt0)); end
            if (gnt1 != 4'd0 && (gnt1 & (gnt1 - 4'd1)) != 4'd0) begin
                n_fail++; $display("FAIL rand_onehot c%0d: got %b expected zero or one-hot", c, gnt1);
            end
            n_checks++;
        end
    endtask

    initial begin
        test_reset();
        test_round_robin();
        test_beat_pattern();
        test_len_zero();
        test_back_to_back();
        test_reset_mid_burst();
`ifdef FETCH_PRIO_EN
        test_fetch_prio();
`endif
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
